// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared load/store encodings, FSM states and alignment helper
package mem_access_unit_pkg;

    localparam logic [2:0] RAM_R_B  = 3'b000;
    localparam logic [2:0] RAM_R_H  = 3'b001;
    localparam logic [2:0] RAM_R_W  = 3'b010;
    localparam logic [2:0] RAM_R_BU = 3'b100;
    localparam logic [2:0] RAM_R_HU = 3'b101;

    localparam logic [1:0] RAM_W_B = 2'b00;
    localparam logic [1:0] RAM_W_H = 2'b01;
    localparam logic [1:0] RAM_W_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // Unknown store widths format as words, so they are checked as words too.
    function automatic logic access_misaligned(input logic we, input logic [2:0] r_op,
                                               input logic [1:0] w_op, input logic [1:0] a);
        logic half;
        logic word;
        half = we ? (w_op == RAM_W_H) : (r_op == RAM_R_H || r_op == RAM_R_HU);
        word = we ? (w_op != RAM_W_B && w_op != RAM_W_H) : (r_op == RAM_R_W);
        return (half && a[0]) || (word && a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// rtl/lsu_lane_fmt.sv - combinational store lane replication/strobes and load extraction/extension
module lsu_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  st_op,
    input  logic [1:0]  st_a,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_a,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_op)
            RAM_W_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_a;
            end
            RAM_W_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_a[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_a)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_a[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_op)
            RAM_R_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            RAM_R_BU: ld_data = {24'b0, ld_byte};
            RAM_R_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            RAM_R_HU: ld_data = {16'b0, ld_half};
            default:  ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store FSM on a req/gnt/rvalid bus; LSU_MISALIGN_CHECK_EN enables misalignment trapping
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_r_op,
    input  logic [1:0]        req_w_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_e  state;
    logic [2:0]  lat_r_op;
    logic [1:0]  lat_a;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    lsu_lane_fmt u_lane_fmt (
        .st_op    (req_w_op),
        .st_a     (req_addr[1:0]),
        .st_data  (req_wdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_op    (lat_r_op),
        .ld_a     (lat_a),
        .ld_word  (bus_rdata),
        .ld_data  (ld_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

    // IDLE stalls combinationally so the decoder's own cycle is already held.
    always_comb begin
        stall = 1'b0;
        if (cpu_rst_n) begin
            case (state)
                ST_IDLE:         stall = req_valid;
                ST_REQ, ST_WAIT: stall = 1'b1;
                default:         stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state     <= ST_IDLE;
            lat_r_op  <= RAM_R_W;
            lat_a     <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= 4'b0;
            bus_wdata <= 32'b0;
            rdata     <= 32'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_r_op  <= req_r_op;
                        lat_a     <= req_addr[1:0];
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_wstrb <= req_we ? st_wstrb : 4'b0;
                        bus_wdata <= req_we ? st_wdata : 32'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (access_misaligned(req_we, req_r_op, req_w_op, req_addr[1:0])) begin
                            rdata <= 32'b0;
                            mis_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= ST_REQ;
                        end
`else
                        bus_req <= 1'b1;
                        state   <= ST_REQ;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= bus_we ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        rdata <= ld_data;
                        state <= ST_DONE;
                    end
                end
                default: begin
`ifdef LSU_MISALIGN_CHECK_EN
                    mis_q <= 1'b0;
`endif
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        cpu_rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_r_op;
    logic [1:0]  req_w_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          done_c;
    } exp_t;
    exp_t sb[$];

    mem_access_unit #(.ADDR_W(32)) dut (
        .cpu_clk    (clk),
        .cpu_rst_n  (cpu_rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_r_op   (req_r_op),
        .req_w_op   (req_w_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k = cycles with gnt low in REQ, r = cycles with rvalid low in WAIT.
    task automatic run_access(input string tag, input logic we, input logic [2:0] rop,
                              input logic [1:0] wop, input logic [31:0] addr,
                              input logic [31:0] wd, input int k, input int r,
                              input logic [31:0] rword, input logic [31:0] exp_rdata,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                              input logic mis);
        exp_t e;
        exp_t got;
        bit   done = 0;
        int   stalls = 0;
        e.rdata  = exp_rdata;
        e.mis    = mis;
        e.done_c = mis ? 1 : (we ? k + 2 : k + 3 + r);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b1;
                req_we    = we;
                req_r_op  = rop;
                req_w_op  = wop;
                req_addr  = addr;
                req_wdata = wd;
                sb.push_back(e);
            end else begin
                req_valid = (c <= k);
                req_we    = $urandom_range(0, 1) == 1;
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            bus_gnt    = !mis && (c == k + 1);
            bus_rvalid = !mis && !we && (c == k + 2 + r);
            bus_rdata  = bus_rvalid ? rword : $urandom;
            #1;
            check({tag, "_bus_req"}, {31'b0, bus_req},
                  {31'b0, (c >= 1 && c <= k + 1 && !mis)});
            if (stall) begin
                stalls++;
                if (c >= 1 && c <= k + 1 && !mis) begin
                    check({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
                    check({tag, "_bus_we"}, {31'b0, bus_we}, {31'b0, we});
                    check({tag, "_bus_wstrb"}, {28'b0, bus_wstrb}, {28'b0, exp_wstrb});
                    if (we) check({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
                end
            end else begin
                done = 1;
                got = sb.pop_front();
                check({tag, "_done_cycle"}, c, got.done_c);
                check({tag, "_stall_cycles"}, stalls, got.done_c);
                check({tag, "_misaligned"}, {31'b0, misaligned}, {31'b0, got.mis});
                if (!we || got.mis) check({tag, "_rdata"}, rdata, got.rdata);
            end
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        req_valid  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        cpu_rst_n  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_r_op   = RAM_R_W;
        req_w_op   = RAM_W_W;
        req_addr   = 32'h1000;
        req_wdata  = 32'hFFFF_FFFF;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        @(negedge clk);
        cpu_rst_n = 1'b1;
        req_valid = 1'b0;

        run_access("sw",  1'b1, RAM_R_W,  RAM_W_W, 32'h1000, 32'hDEADBEEF, 1, 0, 32'h0,
                   32'h0, 32'hDEADBEEF, 4'b1111, 1'b0);
        run_access("lw",  1'b0, RAM_R_W,  RAM_W_W, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF,
                   32'hDEADBEEF, 32'h0, 4'b0000, 1'b0);
        run_access("lb",  1'b0, RAM_R_B,  RAM_W_B, 32'h1003, 32'h0, 0, 0, 32'h80FF7F01,
                   32'hFFFFFF80, 32'h0, 4'b0000, 1'b0);
        run_access("lbu", 1'b0, RAM_R_BU, RAM_W_B, 32'h1003, 32'h0, 0, 1, 32'h80FF7F01,
                   32'h00000080, 32'h0, 4'b0000, 1'b0);
        run_access("sh",  1'b1, RAM_R_W,  RAM_W_H, 32'h1002, 32'h1234ABCD, 0, 0, 32'h0,
                   32'h0, 32'hABCDABCD, 4'b1100, 1'b0);
        run_access("lw_slow", 1'b0, RAM_R_W, RAM_W_W, 32'h2004, 32'h0, 5, 2, 32'h0BADF00D,
                   32'h0BADF00D, 32'h0, 4'b0000, 1'b0);
        run_access("sb",  1'b1, RAM_R_W,  RAM_W_B, 32'h3001, 32'h000000A5, 0, 0, 32'h0,
                   32'h0, 32'hA5A5A5A5, 4'b0010, 1'b0);
        run_access("lh",  1'b0, RAM_R_H,  RAM_W_H, 32'h1002, 32'h0, 0, 0, 32'h80FF7F01,
                   32'hFFFF80FF, 32'h0, 4'b0000, 1'b0);
        run_access("lhu", 1'b0, RAM_R_HU, RAM_W_H, 32'h1002, 32'h0, 1, 0, 32'h80FF7F01,
                   32'h000080FF, 32'h0, 4'b0000, 1'b0);
        run_access("lb0", 1'b0, RAM_R_B,  RAM_W_B, 32'h1000, 32'h0, 0, 0, 32'h80FF7F01,
                   32'h00000001, 32'h0, 4'b0000, 1'b0);
        run_access("lh0", 1'b0, RAM_R_H,  RAM_W_H, 32'h1000, 32'h0, 0, 0, 32'h80FF7F01,
                   32'h00007F01, 32'h0, 4'b0000, 1'b0);

        // Reset while waiting for read data; the late rvalid must not be captured.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_r_op  = RAM_R_W;
        req_addr  = 32'h4000;
        @(negedge clk);
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        @(negedge clk);
        bus_gnt   = 1'b0;
        cpu_rst_n = 1'b0;
        #1;
        check("midrst_stall_in_rst", {31'b0, stall}, 32'd0);
        @(negedge clk);
        cpu_rst_n  = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55AA55AA;
        #1;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_bus_req", {31'b0, bus_req}, 32'd0);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("midrst_rdata_late", rdata, 32'd0);
        check("midrst_stall_late", {31'b0, stall}, 32'd0);

        run_access("lw_after_rst", 1'b0, RAM_R_W, RAM_W_W, 32'h5008, 32'h0, 0, 0, 32'hCAFEF00D,
                   32'hCAFEF00D, 32'h0, 4'b0000, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        run_access("lw_mis", 1'b0, RAM_R_W, RAM_W_W, 32'h1001, 32'h0, 0, 0, 32'h12345678,
                   32'h0, 32'h0, 4'b0000, 1'b1);
        run_access("sh_mis", 1'b1, RAM_R_W, RAM_W_H, 32'h1003, 32'h1111, 0, 0, 32'h0,
                   32'h0, 32'h0, 4'b0000, 1'b1);
`else
        run_access("lw_unal", 1'b0, RAM_R_W, RAM_W_W, 32'h1001, 32'h0, 0, 1, 32'h12345678,
                   32'h12345678, 32'h0, 4'b0000, 1'b0);
        run_access("sh_unal", 1'b1, RAM_R_W, RAM_W_H, 32'h1003, 32'h00002222, 0, 0, 32'h0,
                   32'h0, 32'h22222222, 4'b1100, 1'b0);
`endif
        run_access("sw_tail", 1'b1, RAM_R_W, RAM_W_W, 32'h6000, 32'h01234567, 2, 0, 32'h0,
                   32'h0, 32'h01234567, 4'b1111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
